pipe_add_sub: RTL and testbench

Parametrised, pipelined adder/subtractor for the MIPS datapath; successor to the single-cycle 32-bit adder. Splits a WIDTH-bit add or subtract into STAGES carry-chained chunks, one chunk per pipeline stage, and produces MIPS-relevant flags (carry, signed overflow, zero). Sits between the ID/EX operand registers and the ALU result mux. It uses a valid/ready handshake so it can run at higher clock rates than a flat ripple adder.

---
 rtl/alu_pkg.sv | 15 +
 rtl/pipe_add_sub_if.sv | 28 ++
 rtl/add_chunk.sv | 14 +
 rtl/pipe_add_sub.sv | 150 +++++++++++++++
 tb/tb_pipe_add_sub.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, default geometry and shape check for the pipelined adder
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    // The operand must split into STAGES equal chunks of at least one bit.
    function automatic bit shape_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_add_sub_if.sv
// rtl/pipe_add_sub_if.sv - operand/result handshake bundle for pipe_add_sub
interface pipe_add_sub_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, data0, data1, op, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, data0, data1, op, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero
    );

endinterface

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - CW-bit ripple slice with carry in/out
module add_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipe_add_sub.sv
// rtl/pipe_add_sub.sv - pipelined add/subtract, one carry-chained chunk per stage, global stall
module pipe_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic          clk,
    input  logic          reset,
    pipe_add_sub_if.slave bus
);

    localparam int CW   = WIDTH / STAGES;
    localparam int MSB  = WIDTH - 1;
    localparam int LAST = STAGES - 1;

    if (!shape_ok(WIDTH, STAGES)) begin : g_shape_check
        $error("pipe_add_sub: WIDTH must be a multiple of STAGES");
    end

    logic en;

    // Per-stage view: a_in/b_in/s_in/c_in/v_in feed stage k, s_out/c_out leave it.
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic [WIDTH-1:0] s_out [STAGES];
    logic             c_in  [STAGES];
    logic             c_out [STAGES];
    logic             v_in  [STAGES];
    logic [CW-1:0]    chunk_s [STAGES];

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    assign en = !out_valid_q || bus.out_ready;

    // Subtract folds into A + ~B + 1: B is inverted here and op is the chunk-0 carry.
    assign a_in[0] = bus.data0;
    assign b_in[0] = (bus.op == OP_SUB) ? ~bus.data1 : bus.data1;
    assign c_in[0] = (bus.op == OP_SUB);
    assign s_in[0] = '0;
    assign v_in[0] = bus.in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk #(.CW(CW)) u_add (
            .a    (a_in[k][k*CW +: CW]),
            .b    (b_in[k][k*CW +: CW]),
            .cin  (c_in[k]),
            .s    (chunk_s[k]),
            .cout (c_out[k])
        );

        assign s_out[k][k*CW +: CW] = chunk_s[k];
        if (k > 0) begin : g_lo
            assign s_out[k][k*CW-1:0] = s_in[k][k*CW-1:0];
        end
        if (k < LAST) begin : g_hi
            assign s_out[k][WIDTH-1:(k+1)*CW] = s_in[k][WIDTH-1:(k+1)*CW];
        end
    end

    for (genvar k = 0; k < LAST; k++) begin : g_reg
        logic [WIDTH-1:0] a_d, a_q, b_d, b_q, s_d, s_q;
        logic             c_d, c_q, v_d, v_q;

        always_comb begin
            a_d = a_q;
            b_d = b_q;
            s_d = s_q;
            c_d = c_q;
            v_d = v_q;
            if (en) begin
                a_d = a_in[k];
                b_d = b_in[k];
                s_d = s_out[k];
                c_d = c_out[k];
                v_d = v_in[k];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else begin
                a_q <= a_d;
                b_q <= b_d;
                s_q <= s_d;
                c_q <= c_d;
                v_q <= v_d;
            end
        end

        assign a_in[k+1] = a_q;
        assign b_in[k+1] = b_q;
        assign s_in[k+1] = s_q;
        assign c_in[k+1] = c_q;
        assign v_in[k+1] = v_q;
    end

    // Result and flags only load on real beats so bubbles never disturb the last result.
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_valid_d = v_in[LAST];
            if (v_in[LAST]) begin
                sum_d      = s_out[LAST];
                carry_d    = c_out[LAST];
                overflow_d = (a_in[LAST][MSB] == b_in[LAST][MSB]) &&
                             (s_out[LAST][MSB] != a_in[LAST][MSB]);
                zero_d     = ~|s_out[LAST];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb/tb_pipe_add_sub.sv - self-checking bench for pipe_add_sub (32/4 and 8/1 builds)
module tb_pipe_add_sub;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_add_sub_if #(.WIDTH(32)) bus ();
    pipe_add_sub_if #(.WIDTH(8))  bus8 ();

    pipe_add_sub #(.WIDTH(32), .STAGES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipe_add_sub #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        ov;
        logic        z;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] sum;
        logic        c;
        logic        ov;
        logic        z;
    } vec_t;

    // Reference: signed 64-bit arithmetic for the result/overflow, unsigned compare for carry.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
        res_t        m;
        longint      sa;
        longint      sb;
        longint      r;
        logic [32:0] usum;
        sa = $signed(a);
        sb = $signed(b);
        r  = op ? (sa - sb) : (sa + sb);
        usum = {1'b0, a} + {1'b0, b};
        m.sum = r[31:0];
        m.c   = op ? (a >= b) : usum[32];
        m.ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        m.z   = (m.sum == 32'd0);
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic op,
                            output res_t r, output int lat);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.data0     = a;
        bus.data1     = b;
        bus.op        = op;
        bus.in_valid  = 1'b1;
        check("send_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r.sum = bus.sum;
        r.c   = bus.carry_out;
        r.ov  = bus.overflow;
        r.z   = bus.zero;
    endtask

    task automatic run_stream(input int n, input bit directed);
        res_t        expq[$];
        res_t        e;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        int          stalls = 0;
        int          stall_left = 3;
        bit          acc = 1'b0;
        bit          seen = 1'b0;
        bit          prev_stall = 1'b0;
        logic [34:0] prev_out = '0;
        bus.in_valid = 1'b0;
        while (got < n && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (acc || !bus.in_valid) begin
                if (sent < n && (directed || $urandom_range(0, 3) != 0)) begin
                    bus.in_valid = 1'b1;
                    bus.data0    = directed ? 32'(sent) : $urandom;
                    bus.data1    = directed ? 32'h10 : $urandom;
                    bus.op       = directed ? OP_ADD : 1'($urandom_range(0, 1));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (directed) begin
                if (seen && stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end else begin
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                expq.push_back(model(bus.data0, bus.data1, bus.op));
                sent++;
            end
            if (prev_stall)
                check("stall_hold", {28'd0, bus.out_valid, bus.sum, bus.carry_out, bus.overflow, bus.zero},
                      {28'd0, 1'b1, prev_out});
            if (bus.out_valid) seen = 1'b1;
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                got++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra: result %h with no beat outstanding", bus.sum);
                end else begin
                    e = expq.pop_front();
                    check("stream_result", {29'd0, bus.sum, bus.carry_out, bus.overflow, bus.zero},
                          {29'd0, e.sum, e.c, e.ov, e.z});
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.sum, bus.carry_out, bus.overflow, bus.zero};
        end
        check("stream_count", 64'(got), 64'(n));
        check("stream_leftover", 64'(expq.size()), 64'd0);
        if (directed) check("stall_cycles", 64'(stalls), 64'd3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        vec_t vt[6];
        res_t r;
        int   lat;
        int   stale;

        vt[0] = '{32'h000000FF, 32'h00000001, OP_ADD, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vt[1] = '{32'h7FFFFFFF, 32'h00000001, OP_ADD, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[2] = '{32'hFFFFFFFF, 32'h00000001, OP_ADD, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[3] = '{32'h00000005, 32'h00000005, OP_SUB, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[4] = '{32'h80000000, 32'h00000001, OP_SUB, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vt[5] = '{32'h00000003, 32'h00000005, OP_SUB, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        bus.in_valid = 1'b0;  bus.data0 = '0;  bus.data1 = '0;  bus.op = OP_ADD;  bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.data0 = '0; bus8.data1 = '0; bus8.op = OP_ADD; bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_flags", {29'd0, bus.sum, bus.carry_out, bus.overflow, bus.zero}, 64'd0);
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("reset8_state", {54'd0, bus8.out_valid, bus8.sum, bus8.carry_out}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            send_one(vt[i].a, vt[i].b, vt[i].op, r, lat);
            check($sformatf("vec%0d_sum", i), {32'd0, r.sum}, {32'd0, vt[i].sum});
            check($sformatf("vec%0d_flags", i), {61'd0, r.c, r.ov, r.z}, {61'd0, vt[i].c, vt[i].ov, vt[i].z});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
        end

        run_stream(6, 1'b1);
        run_stream(200, 1'b0);

        // Reset with beats in flight and one already presented.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.data0    = 32'(100 * (i + 1));
            bus.data1    = 32'd1;
            bus.op       = OP_ADD;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_result", {31'd0, bus.out_valid, bus.sum}, {31'd0, 1'b1, 32'd101});
        reset = 1'b1;
        #1;
        check("async_reset_out", {31'd0, bus.out_valid, bus.sum}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        send_one(32'd2, 32'd3, OP_ADD, r, lat);
        check("post_reset_sum", {32'd0, r.sum}, 64'd5);
        check("post_reset_latency", 64'(lat), 64'd4);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale++;
        end
        check("no_stale_beats", 64'(stale), 64'd0);

        // Single-stage build: result is visible one edge after accept.
        @(posedge clk);
        #1;
        bus8.data0 = 8'hFF; bus8.data1 = 8'h01; bus8.op = OP_ADD; bus8.in_valid = 1'b1;
        @(negedge clk);
        check("s1_pre_accept", {62'd0, bus8.in_ready, bus8.out_valid}, 64'd2);
        @(posedge clk);
        #1;
        bus8.data0 = 8'h80; bus8.data1 = 8'h01; bus8.op = OP_SUB;
        check("s1_add", {53'd0, bus8.out_valid, bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero},
              {53'd0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        check("s1_sub", {53'd0, bus8.out_valid, bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero},
              {53'd0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        check("s1_drain", {63'd0, bus8.out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
